// File: rtl/common_bus_pkg.sv
// ============================================================================
// Module  : common_bus_pkg
// Purpose : Select encoding and sequencer state type for the common bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

package common_bus_pkg;

    localparam int SRC_EXT = 0;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } seq_state_t;

    // Bus select code for register k (registers start right after data_in).
    function automatic int src_reg(input int k);
        return k + 1;
    endfunction

    function automatic int src_mdr(input int nreg);
        return nreg + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_mem_seq.sv
// ============================================================================
// Module  : bus_mem_seq
// Purpose : Multi-cycle memory read/write sequencer with MDR and handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_mem_seq
    import common_bus_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_mdr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_drop
);

    localparam int C_CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_CNT_W-1:0]  w_cnt_nxt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_done;
    logic                r_drop;
    logic                w_accept;
    logic                w_commit;
    logic [DATA_W-1:0]   r_mem [2**ADDR_W];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = C_CNT_W'(MEM_LAT - 1);
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mdr   <= '0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_commit;
            r_drop  <= i_req && (r_state == ST_ACCESS);
            if (w_accept) begin
                r_we    <= i_we;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
            if (w_commit && !r_we) begin
                r_mdr <= r_mem[r_addr];
            end
        end
    end

    // Reset forces IDLE asynchronously, so an aborted write can never commit.
    always_ff @(posedge clk) begin
        if (w_commit && r_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // Busy covers the done cycle too; a request sampled at its end is accepted.
    assign o_busy = (r_state == ST_ACCESS) | r_done;
    assign o_done = r_done;
    assign o_drop = r_drop;
    assign o_mdr  = r_mdr;

endmodule

`default_nettype wire

// File: rtl/common_bus_gen.sv
// ============================================================================
// Module  : common_bus_gen
// Purpose : Parametrised common bus: register file, bus mux, memory sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module common_bus_gen
    import common_bus_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int NREG    = 6,
    parameter int MEM_LAT = 1,
    parameter int SEL_W   = $clog2(NREG + 2)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [SEL_W-1:0]  select,
    input  logic [DATA_W-1:0] data_in,
    input  logic [NREG-1:0]   ld,
    input  logic [NREG-1:0]   inr,
    input  logic [NREG-1:0]   clr,
    input  logic              mem_req,
    input  logic              mem_we,
    output logic [DATA_W-1:0] data_out,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              req_drop,
    output logic              sel_err
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] w_bus;
    logic [DATA_W-1:0] w_mdr;

    always_comb begin
        w_bus = '0;
        if (select == SEL_W'(SRC_EXT)) begin
            w_bus = data_in;
        end
        for (int k = 0; k < NREG; k++) begin
            if (select == SEL_W'(src_reg(k))) begin
                w_bus = r_regs[k];
            end
        end
        if (select == SEL_W'(src_mdr(NREG))) begin
            w_bus = w_mdr;
        end
    end

    assign data_out = w_bus;
    assign sel_err  = (select > SEL_W'(src_mdr(NREG)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREG; k++) begin
                if (clr[k]) begin
                    r_regs[k] <= '0;
                end else if (ld[k]) begin
                    r_regs[k] <= w_bus;
                end else if (inr[k]) begin
                    r_regs[k] <= r_regs[k] + 1'b1;
                end
            end
        end
    end

    bus_mem_seq #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (MEM_LAT)
    ) u_seq (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_req   (mem_req),
        .i_we    (mem_we),
        .i_addr  (r_regs[0][ADDR_W-1:0]),
        .i_wdata (w_bus),
        .o_mdr   (w_mdr),
        .o_busy  (mem_busy),
        .o_done  (mem_done),
        .o_drop  (req_drop)
    );

endmodule

`default_nettype wire

// File: tb/tb_common_bus_gen.sv
// ============================================================================
// Module  : tb_common_bus_gen
// Purpose : Directed self-checking bench for common_bus_gen.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_common_bus_gen;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  select = '0;
    logic [15:0] data_in = '0;
    logic [5:0]  ld = '0, inr = '0, clr = '0;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [15:0] data_out;
    logic        mem_busy, mem_done, req_drop, sel_err;

    // Second instance with NREG=7 so that out-of-range select codes exist.
    logic [3:0]  e_select = '0;
    logic [15:0] e_data_in = '0;
    logic [6:0]  e_ld = '0, e_inr = '0, e_clr = '0;
    logic [15:0] e_data_out;
    logic        e_busy, e_done, e_drop, e_sel_err;

    int n_checks = 0;
    int n_err = 0;
    logic [15:0] rd;

    always #5 clock = ~clock;

    common_bus_gen #(.DATA_W(16), .ADDR_W(12), .NREG(6), .MEM_LAT(3)) dut (
        .clock(clock), .reset_n(reset_n), .select(select), .data_in(data_in),
        .ld(ld), .inr(inr), .clr(clr), .mem_req(mem_req), .mem_we(mem_we),
        .data_out(data_out), .mem_busy(mem_busy), .mem_done(mem_done),
        .req_drop(req_drop), .sel_err(sel_err)
    );

    common_bus_gen #(.DATA_W(16), .ADDR_W(12), .NREG(7), .MEM_LAT(1)) dut_e (
        .clock(clock), .reset_n(reset_n), .select(e_select), .data_in(e_data_in),
        .ld(e_ld), .inr(e_inr), .clr(e_clr), .mem_req(1'b0), .mem_we(1'b0),
        .data_out(e_data_out), .mem_busy(e_busy), .mem_done(e_done),
        .req_drop(e_drop), .sel_err(e_sel_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Load reg0 with addr, issue one access, wait for done, sample MDR.
    task automatic do_access(input logic [15:0] addr, input logic we,
                             input logic [15:0] wd, output logic [15:0] rdata);
        int n;
        select = 3'd0; data_in = addr; ld = 6'b000001; tick(); ld = '0;
        data_in = wd; mem_req = 1'b1; mem_we = we; tick();
        mem_req = 1'b0; mem_we = 1'b0;
        n = 0;
        while (!mem_done && n < 20) begin
            tick();
            n++;
        end
        if (!mem_done) check_eq("done_timeout", 32'd0, 32'd1);
        select = 3'd7; #1;
        rdata = data_out;
        select = 3'd0;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        #1 reset_n = 1'b0;
        data_in = 16'h5A5A;
        #1;
        check_eq("rst_ext", data_out, 16'h5A5A);
        check_eq("rst_busy", mem_busy, 0);
        check_eq("rst_done", mem_done, 0);
        check_eq("rst_drop", req_drop, 0);
        check_eq("rst_selerr", sel_err, 0);
        for (int s = 1; s <= 7; s++) begin
            select = 3'(s); #1;
            check_eq("rst_reg", data_out, 0);
        end
        select = 3'd0;
        tick();
        reset_n = 1'b1;
        tick();

        // ---------------- load / clear priority ----------------
        data_in = 16'h1234; ld = 6'b000100; tick(); ld = '0;
        select = 3'd3; #1;
        check_eq("ld_reg2", data_out, 16'h1234);
        clr = 6'b000100; ld = 6'b000100; inr = 6'b000100; tick();
        clr = '0; ld = '0; inr = '0;
        check_eq("clr_prio", data_out, 16'h0000);

        select = 3'd0; data_in = 16'h0010; ld = 6'b000010; inr = 6'b000010; tick();
        ld = '0; inr = '0;
        select = 3'd2; #1;
        check_eq("ld_over_inr", data_out, 16'h0010);
        ld = 6'b000010; tick(); ld = '0;
        check_eq("self_load", data_out, 16'h0010);
        inr = 6'b000010; tick(); inr = '0;
        check_eq("inr_reg1", data_out, 16'h0011);

        // ---------------- increment wrap ----------------
        select = 3'd0; data_in = 16'hFFFF; ld = 6'b001000; tick(); ld = '0;
        select = 3'd4; #1;
        check_eq("ld_reg3", data_out, 16'hFFFF);
        inr = 6'b001000; tick(); inr = '0;
        check_eq("inr_wrap", data_out, 16'h0000);
        select = 3'd7; #1;
        check_eq("mdr_sel_ok", sel_err, 0);

        // ---------------- write then read, MEM_LAT=3 ----------------
        select = 3'd0; data_in = 16'h0FFE; ld = 6'b000001; tick(); ld = '0;
        // reg0 reload in the request cycle must not affect this access's address
        data_in = 16'h6789; ld = 6'b000001; mem_req = 1'b1; mem_we = 1'b1; tick();
        ld = '0; mem_req = 1'b0; mem_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("wr_busy", mem_busy, (i < 4) ? 1 : 0);
            check_eq("wr_done", mem_done, (i == 3) ? 1 : 0);
            if (i < 4) tick();
        end
        select = 3'd1; #1;
        check_eq("reg0_loaded", data_out, 16'h6789);

        select = 3'd0; data_in = 16'h0FFE; ld = 6'b000001; tick(); ld = '0;
        select = 3'd7; mem_req = 1'b1; mem_we = 1'b0; tick(); mem_req = 1'b0;
        check_eq("rd_mdr_early", data_out, 16'h0000);
        tick(); tick(); tick();
        check_eq("rd_done", mem_done, 1);
        check_eq("rd_data", data_out, 16'h6789);
        select = 3'd0;
        tick();

        // ---------------- dropped request ----------------
        do_access(16'h0200, 1'b1, 16'h2222, rd);
        select = 3'd0; data_in = 16'h0100; ld = 6'b000001; tick(); ld = '0;
        data_in = 16'h1111; mem_req = 1'b1; mem_we = 1'b1; tick(); mem_req = 1'b0;
        check_eq("drop_idle", req_drop, 0);
        data_in = 16'h0200; ld = 6'b000001; tick(); ld = '0;
        data_in = 16'h5555; mem_req = 1'b1; mem_we = 1'b1; tick();
        mem_req = 1'b0; mem_we = 1'b0;
        check_eq("drop_pulse", req_drop, 1);
        tick();
        check_eq("drop_once", req_drop, 0);
        check_eq("drop_done", mem_done, 1);
        tick();
        check_eq("drop_nobusy", mem_busy, 0);
        do_access(16'h0200, 1'b0, 16'h0000, rd);
        check_eq("drop_tgt_kept", rd, 16'h2222);
        do_access(16'h0100, 1'b0, 16'h0000, rd);
        check_eq("drop_first_ok", rd, 16'h1111);

        // ---------------- reset abort ----------------
        do_access(16'h0FFD, 1'b1, 16'hAAAA, rd);
        select = 3'd0; data_in = 16'h0FFD; ld = 6'b000001; tick(); ld = '0;
        data_in = 16'h1234; mem_req = 1'b1; mem_we = 1'b1; tick();
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        reset_n = 1'b0; #1;
        check_eq("abort_busy", mem_busy, 0);
        check_eq("abort_done", mem_done, 0);
        check_eq("abort_drop", req_drop, 0);
        for (int s = 1; s <= 7; s++) begin
            select = 3'(s); #1;
            check_eq("abort_reg", data_out, 0);
        end
        select = 3'd0;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick(); tick(); tick();
        check_eq("abort_idle", mem_busy, 0);
        do_access(16'h0FFD, 1'b0, 16'h0000, rd);
        check_eq("abort_nowrite", rd, 16'hAAAA);

        // ---------------- select error ----------------
        e_select = 4'd0; e_data_in = 16'hBEEF; e_ld = 7'b0000010; tick(); e_ld = '0;
        e_select = 4'd2; #1;
        check_eq("e_ld_reg1", e_data_out, 16'hBEEF);
        e_select = 4'd8; #1;
        check_eq("e_mdr_ok", e_sel_err, 0);
        e_select = 4'd9; #1;
        check_eq("e_err9", e_sel_err, 1);
        check_eq("e_bus9", e_data_out, 0);
        e_ld = 7'b0000010; tick(); e_ld = '0;
        e_select = 4'd2; #1;
        check_eq("e_ld_err", e_data_out, 16'h0000);
        e_select = 4'd15; #1;
        check_eq("e_err15", e_sel_err, 1);
        check_eq("e_bus15", e_data_out, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/common_bus_gen.md
# common_bus_gen

Parametrised successor to the fixed 16-bit common bus. It provides a register file of NREG bus-attached registers with per-register load, increment and clear. A select-driven bus multiplexer chooses the bus source. Memory access runs through a multi-cycle read/write sequencer with a busy/done handshake and a configurable access latency. The block sits between the control unit (which drives select/ld/inr/clr/mem_req) and the rest of the datapath, which sees `data_out`.

## Interface

**Parameters**
- `DATA_W`, 16: bus and register width.
- `ADDR_W`, 12: memory address width; memory depth is 2**ADDR_W words.
- `NREG`, 6: number of bus registers, 2..14. Register 0 is the address register.
- `MEM_LAT`, 1: cycles from request acceptance to memory commit, ≥1.
- `SEL_W`, $clog2(NREG+2): select width (derived; do not override).

**Ports**
- `clock` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `select` in SEL_W: bus source.
  - 0 = `data_in`.
  - k = register k-1, for 1..NREG.
  - NREG+1 = MDR (memory data register).
- `data_in` in DATA_W: external bus source.
- `ld` in NREG: per-register load from bus.
- `inr` in NREG: per-register increment.
- `clr` in NREG: per-register clear.
- `mem_req` in 1: memory access request.
- `mem_we` in 1: 1 = write, 0 = read; sampled with `mem_req`.
- `data_out` out DATA_W: current bus value (combinational).
- `mem_busy` out 1: access in progress.
- `mem_done` out 1: one-cycle completion pulse.
- `req_drop` out 1: one-cycle pulse when `mem_req` arrives while busy.
- `sel_err` out 1: combinational; `select` > NREG+1.

## Operation

**Bus**
- `data_out` is a pure mux of the selected source.
- An out-of-range `select` drives 0 and raises `sel_err`.

**Register update** (per register, at each rising edge)
- Priority is `clr` > `ld` > `inr`.
- `clr` writes 0.
- `ld` loads `data_out` sampled before the edge.
- `inr` adds 1 modulo 2**DATA_W, so 0xFFFF wraps to 0x0000.
- A register loading from itself via the bus holds its value.
- The memory address is reg0[ADDR_W-1:0]; upper bits are ignored.

**Sequencer FSM: IDLE → ACCESS → IDLE**
- **IDLE:** on `mem_req`=1, latch `mem_we`, the address (pre-edge reg0) and the write data (pre-edge `data_out`), load the latency counter with MEM_LAT-1, and go to ACCESS.
- **ACCESS:**
  - While the counter is nonzero, decrement it.
  - When the counter is 0, commit and return to IDLE.
  - A write commit performs mem[addr] ← wdata.
  - A read commit performs MDR ← mem[addr].
  - `mem_done` registers high for the following cycle.
- **Dropped request:** `mem_req` in ACCESS is ignored and pulses `req_drop` in the next cycle. The latched operation is unaffected.

**Fixed behaviours**
- Memory contents are not reset.
- MDR is written only by a read commit.

## Timing

**Reset values.** With `reset_n`=0:
- All registers, MDR, `mem_busy`, `mem_done` and `req_drop` are 0.
- The FSM is in IDLE.
- `data_out` follows the select mux; with select=0 it equals `data_in`.

**Reset mid-access.** Reset during ACCESS aborts the access: no memory write and no MDR update occur.

**Access latency.** For a request accepted at edge T:
- `mem_busy` is 1 for cycles T..T+MEM_LAT.
- The commit happens at edge T+MEM_LAT.
- `mem_done` is 1 for exactly the cycle after T+MEM_LAT.
- A new request may be accepted at edge T+MEM_LAT+1, so peak throughput is 1 access per MEM_LAT+1 cycles.

**Read data visibility.** Read data is visible on the bus (select=NREG+1) in the `mem_done` cycle.

**Simultaneous events**
- `ld[0]` together with `mem_req` in the same cycle: the access uses the old reg0.
- A write request together with `ld` of any register: the write data is the pre-edge bus value.
- `clr`, `ld` and `inr` are independent per register.

## Structure

**Package `common_bus_pkg`**
- Select-encoding constants: `SRC_EXT`=0, plus a function `src_reg(k)` and a function `src_mdr(NREG)`.
- FSM state encoding: `ST_IDLE`, `ST_ACCESS`.

**Sub-module `bus_mem_seq`**
- Contains the FSM, latency counter, address/data/we latches, memory array, MDR, and the `mem_busy`, `mem_done` and `req_drop` outputs.
- Parameters: `DATA_W`, `ADDR_W`, `MEM_LAT`.

**Top level `common_bus_gen`**
- Contains the register file, the bus mux and `sel_err`.

## Test plan

All scenarios use defaults unless noted.

- **Load/clear priority.** Set data_in=0x1234, select=0, ld[2]=1 for 1 edge, so reg2=0x1234. Then apply clr[2]=ld[2]=inr[2]=1 → reg2=0x0000 after one edge.
- **Increment wrap.** Load reg3=0xFFFF via the bus, then pulse inr[3] → reg3=0x0000 and data_out=0x0000 with select=4.
- **Write then read, MEM_LAT=3.**
  - Load reg0=0x0FFE, then request a write with data_in=0x6789 → mem_busy high for 4 cycles, mem_done 1 cycle later.
  - A read request to the same address → MDR=0x6789 and, with select=NREG+1, data_out=0x6789 in the mem_done cycle.
- **Dropped request.** Issue a second mem_req during ACCESS → req_drop pulses once, only the first access commits, and the target address of the second is unchanged.
- **Reset abort.** Assert reset_n=0 mid-write (0x0FFD ← 0x1234, MEM_LAT=3) → a later read of 0x0FFD returns the prior contents, and all registers and outputs are 0 during reset.
- **Select error.** Set select=NREG+2 → data_out=0 and sel_err=1. Loading any register from this bus value yields 0.
